// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin arbiter sharing one registered logic-op unit among NREQ requesters
// Optional: LOGIC_ARB_STAT_EN adds saturating grant/stall counters.
module logic_op_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [3*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_a,
    input  logic [WIDTH*NREQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_y,
    output logic                   rsp_err
`ifdef LOGIC_ARB_STAT_EN
    ,
    output logic [15:0]            stat_grants,
    output logic [15:0]            stat_stalls
`endif
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;

    logic             free;
    logic             grant_found;
    logic             grant_ok;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    assign free = !valid_q || rsp_ready;

    // Search starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_ok = rst_n && free && grant_found;

    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                req_ready[i] = grant_ok;
                sel_op       = req_op[3*i +: 3];
                sel_a        = req_a[WIDTH*i +: WIDTH];
                sel_b        = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (sel_op)
            OP_AND:  alu_y = sel_a & sel_b;
            OP_OR:   alu_y = sel_a | sel_b;
            OP_NOT:  alu_y = ~sel_a;
            OP_NAND: alu_y = ~(sel_a & sel_b);
            OP_NOR:  alu_y = ~(sel_a | sel_b);
            default: alu_err = 1'b1;
        endcase
    end

    // A grant in the same cycle as a drain overwrites the slot, so no bubble appears.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        id_d    = id_q;
        y_d     = y_q;
        err_d   = err_q;
        if (grant_ok) begin
            ptr_d   = grant_idx;
            valid_d = 1'b1;
            id_d    = grant_idx;
            y_d     = alu_y;
            err_d   = alu_err;
        end else if (valid_q && rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= IDW'(NREQ - 1);
            valid_q <= 1'b0;
            id_q    <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_y     = y_q;
    assign rsp_err   = err_q;

`ifdef LOGIC_ARB_STAT_EN
    logic [15:0] grants_q, grants_d;
    logic [15:0] stalls_q, stalls_d;

    always_comb begin
        grants_d = grants_q;
        stalls_d = stalls_q;
        if (grant_ok && grants_q != 16'hFFFF) begin
            grants_d = grants_q + 16'd1;
        end
        if ((|req_valid) && !free && stalls_q != 16'hFFFF) begin
            stalls_d = stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else begin
            grants_q <= grants_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_err;
`ifdef LOGIC_ARB_STAT_EN
    logic [15:0]           stat_grants;
    logic [15:0]           stat_stalls;
`endif

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err)
`ifdef LOGIC_ARB_STAT_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int              m_ptr   = NREQ - 1;
    bit              m_valid = 1'b0;
    int              m_id    = 0;
    logic [7:0]      m_y     = 8'h00;
    bit              m_err   = 1'b0;
    int              m_gr    = 0;
    int              m_st    = 0;
    int              exp_g;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] last_ready;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       err;
    } vec_t;
    vec_t tv[7];

    bit         pend[NREQ];
    logic [2:0] p_op[NREQ];
    logic [7:0] p_a[NREQ];
    logic [7:0] p_b[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            0: return {1'b0, a & b};
            1: return {1'b0, a | b};
            2: return {1'b0, ~a};
            3: return {1'b0, ~(a & b)};
            4: return {1'b0, ~(a | b)};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    task automatic model_ready();
        exp_ready = '0;
        exp_g = -1;
        if (rst_n && (!m_valid || rsp_ready)) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (exp_g < 0 && req_valid[c]) exp_g = c;
            end
        end
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
    endtask

    task automatic model_clock();
        logic [8:0] r;
        if (!rst_n) begin
            m_ptr = NREQ - 1; m_valid = 0; m_id = 0; m_y = 0; m_err = 0; m_gr = 0; m_st = 0;
        end else begin
            if ((|req_valid) && m_valid && !rsp_ready && m_st < 65535) m_st++;
            if (exp_g >= 0) begin
                r = ref_op(int'(req_op[3*exp_g +: 3]), req_a[8*exp_g +: 8], req_b[8*exp_g +: 8]);
                m_valid = 1; m_id = exp_g; m_y = r[7:0]; m_err = r[8]; m_ptr = exp_g;
                if (m_gr < 65535) m_gr++;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
    endtask

    // Inputs are set at the falling edge by the caller; one call covers one clock.
    task automatic step();
        #1;
        model_ready();
        last_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        model_clock();
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_y", 32'(rsp_y), 32'(m_y));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
`ifdef LOGIC_ARB_STAT_EN
        chk("stat_grants", 32'(stat_grants), 32'(m_gr));
        chk("stat_stalls", 32'(stat_stalls), 32'(m_st));
`endif
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        tv[0] = '{3'd0, 8'hCC, 8'hAA, 8'h88, 1'b0};
        tv[1] = '{3'd1, 8'hCC, 8'hAA, 8'hEE, 1'b0};
        tv[2] = '{3'd2, 8'hCC, 8'hAA, 8'h33, 1'b0};
        tv[3] = '{3'd3, 8'hCC, 8'hAA, 8'h77, 1'b0};
        tv[4] = '{3'd4, 8'hCC, 8'hAA, 8'h11, 1'b0};
        tv[5] = '{3'd6, 8'hFF, 8'h00, 8'h00, 1'b1};
        tv[6] = '{3'd2, 8'h0F, 8'h00, 8'hF0, 1'b0};

        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0;
        @(negedge clk);

        // Reset held two cycles with all requesters valid
        for (int i = 0; i < 2; i++) begin
            step();
            chk("reset_ready", 32'(last_ready), 32'h0);
            chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("reset_rsp_y", 32'(rsp_y), 32'h0);
        end
        rst_n = 1'b1;
        step();
        chk("first_grant", 32'(last_ready), 32'h1);

        // Truth table through requester 1
        do_reset();
        req_valid = 4'b0010; rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_req(1, tv[i].op, tv[i].a, tv[i].b);
            step();
            chk("tt_y", 32'(rsp_y), 32'(tv[i].y));
            chk("tt_err", 32'(rsp_err), 32'(tv[i].err));
            chk("tt_id", 32'(rsp_id), 32'h1);
        end

        // Round-robin fairness, then requester 1 drops out
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_id", 32'(rsp_id), 32'(i % 4));
        end
        req_valid = 4'b1101;
        begin
            int seq[4] = '{0, 2, 3, 0};
            for (int i = 0; i < 4; i++) begin
                step();
                chk("rr_skip_id", 32'(rsp_id), 32'(seq[i]));
            end
        end

        // Back-pressure: pending result owned by requester 0
        req_valid = 4'hF; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", 32'(last_ready), 32'h0);
            chk("bp_id_hold", 32'(rsp_id), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_grant", 32'(last_ready), 32'h2);
        chk("bp_no_bubble", 32'(rsp_valid), 32'h1);
        chk("bp_release_id", 32'(rsp_id), 32'h1);

        // Five grants and three stalled cycles, then reset mid-stall
        do_reset();
        req_valid = 4'b0001; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
`ifdef LOGIC_ARB_STAT_EN
        chk("stat_grants_5", 32'(stat_grants), 32'd5);
        chk("stat_stalls_3", 32'(stat_stalls), 32'd3);
`endif
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(rsp_valid), 32'h0);
`ifdef LOGIC_ARB_STAT_EN
        chk("midrst_grants", 32'(stat_grants), 32'd0);
        chk("midrst_stalls", 32'(stat_stalls), 32'd0);
`endif
        rst_n = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
        step();
        chk("midrst_ptr", 32'(last_ready), 32'h1);

        // Randomized traffic obeying the hold-until-ready rule
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    p_op[i] = 3'($urandom_range(0, 7));
                    p_a[i]  = 8'($urandom);
                    p_b[i]  = 8'($urandom);
                end
                req_valid[i] = pend[i];
                set_req(i, p_op[i], p_a[i], p_b[i]);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            step();
            for (int i = 0; i < NREQ; i++) if (last_ready[i]) pend[i] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
